// File: rtl/mem_responder.sv
// Single-port word memory responder with a fixed request-to-ack latency and one
// outstanding request. Writes commit at acceptance, reads are served in the response cycle.
module mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int LAT       = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        MemRead,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   idx_q;
  logic            read_q;
  logic            bad_q;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   idx_d;
  logic            addr_bad;
  logic            accept;

  // Upper address bits above the array are an error, as is any sub-word offset.
  assign idx_d    = addr[AW+1:2];
  assign addr_bad = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  assign accept   = CS && ready;

  // NOTE: the array has no reset; contents must survive rst, and a resettable
  // array would also prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && accept && !MemRead && !addr_bad)
      mem[idx_d] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      ack    <= 1'b0;
      cnt    <= '0;
      idx_q  <= '0;
      read_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CS) begin
            idx_q  <= idx_d;
            read_q <= MemRead;
            bad_q  <= addr_bad;
            ready  <= 1'b0;
            if (LAT == 1) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CW'(LAT - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state <= RESP;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          ready <= 1'b1;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign err   = ack && bad_q;
  assign rdata = (ack && read_q && !bad_q) ? mem[idx_q] : 32'h0;

endmodule
